// File: rtl/counter_overflow.sv
// ============================================================================
// Module   : counter_overflow
// Brief    : Saturating up-counter with a sticky flag raised once count > i_LIM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_overflow #(
    parameter int COUNTER_BITS = 32
) (
    input  wire logic                    i_CLK,
    input  wire logic                    i_RST,
    input  wire logic [COUNTER_BITS-1:0] i_LIM,
    output logic                         o_OVERFLOW
);

    localparam logic [COUNTER_BITS-1:0] c_CNT_MAX = '1;
    localparam logic [COUNTER_BITS-1:0] c_CNT_ONE = COUNTER_BITS'(1);

    logic [COUNTER_BITS-1:0] r_count;
    logic [COUNTER_BITS-1:0] w_next;
    logic                    w_exceed;

    // Holding at all-ones means an all-ones limit can never be exceeded.
    assign w_next   = (r_count == c_CNT_MAX) ? r_count : (r_count + c_CNT_ONE);
    assign w_exceed = (w_next > i_LIM);

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_count    <= '0;
            o_OVERFLOW <= 1'b0;
        end else if (!o_OVERFLOW) begin
            r_count <= w_next;
            if (w_exceed) begin
                o_OVERFLOW <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_counter_overflow.sv
// ============================================================================
// Module   : tb_counter_overflow
// Brief    : Scoreboard bench for counter_overflow at 32-bit and 4-bit widths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_overflow;

    logic        clk;
    logic        rst;
    logic [31:0] lim32;
    logic [3:0]  lim4;
    logic        ovf32;
    logic        ovf4;

    int n_tests;
    int n_fail;
    int n_step;

    typedef struct {
        longint c32;
        bit     f32;
        longint c4;
        bit     f4;
        int     idx;
    } exp_t;

    exp_t q[$];

    // Reference state: plain integers, clamped with min() instead of bit widths.
    longint m_c32;
    bit     m_f32;
    longint m_c4;
    bit     m_f4;

    counter_overflow #(.COUNTER_BITS(32)) dut32 (
        .i_CLK      (clk),
        .i_RST      (rst),
        .i_LIM      (lim32),
        .o_OVERFLOW (ovf32)
    );

    counter_overflow #(.COUNTER_BITS(4)) dut4 (
        .i_CLK      (clk),
        .i_RST      (rst),
        .i_LIM      (lim4),
        .o_OVERFLOW (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint lmin(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string name, input int idx, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input bit r, input longint l32, input longint l4);
        exp_t e;
        @(negedge clk);
        rst   = r;
        lim32 = 32'(l32);
        lim4  = 4'(l4);
        if (r) begin
            m_c32 = 0; m_f32 = 0;
            m_c4  = 0; m_f4  = 0;
        end else begin
            if (!m_f32) begin
                m_c32 = lmin(m_c32 + 1, 64'd4294967295);
                if (m_c32 > l32) m_f32 = 1;
            end
            if (!m_f4) begin
                m_c4 = lmin(m_c4 + 1, 15);
                if (m_c4 > l4) m_f4 = 1;
            end
        end
        e.c32 = m_c32; e.f32 = m_f32;
        e.c4  = m_c4;  e.f4  = m_f4;
        e.idx = n_step;
        n_step++;
        q.push_back(e);
    endtask

    // Monitor: the DUT presents a fresh result after every edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("count32", e.idx, longint'(dut32.r_count), e.c32);
            check("ovf32",   e.idx, longint'(ovf32),         longint'(e.f32));
            check("count4",  e.idx, longint'(dut4.r_count),  e.c4);
            check("ovf4",    e.idx, longint'(ovf4),          longint'(e.f4));
        end
    end

    initial begin
        int wait_cycles;
        n_tests = 0; n_fail = 0; n_step = 0;
        m_c32 = 0; m_f32 = 0; m_c4 = 0; m_f4 = 0;
        rst = 1'b1; lim32 = '0; lim4 = '0;

        // Basic limit 5 overflow and freeze.
        step(1, 5, 15);
        repeat (8) step(0, 5, 15);
        // Reset after overflow.
        step(1, 5, 15);
        repeat (3) step(0, 5, 15);
        // Mid-count reset.
        step(1, 5, 15);
        repeat (3) step(0, 5, 15);
        step(1, 5, 15);
        repeat (15) step(0, 5, 15);
        // Zero limit.
        step(1, 0, 0);
        repeat (4) step(0, 0, 0);
        // Limit lowered below current count, then raised again.
        step(1, 10, 15);
        repeat (4) step(0, 10, 15);
        step(0, 2, 15);
        repeat (3) step(0, 10, 15);
        // Saturation of the 4-bit instance, plus all-ones limit on the 32-bit one.
        step(1, 64'd4294967295, 15);
        repeat (20) step(0, 64'd4294967295, 15);
        // Reset held for several edges.
        repeat (3) step(1, 3, 3);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            bit     r;
            longint l32;
            longint l4;
            r   = ($urandom_range(0, 19) == 0);
            l32 = ($urandom_range(0, 9) == 0) ? 64'd4294967295 : longint'($urandom_range(0, 40));
            l4  = longint'($urandom_range(0, 15));
            step(r, l32, l4);
        end

        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0 pending", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
